// File: rtl/fd_pipe_reg.sv
// Fetch-to-decode pipeline register with stall/flush control, a saturating
// stall counter and the decode-side field slicing and extender-mode decode.
module fd_pipe_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_F,
  input  logic [31:0] PC_F,
  input  logic        Stall,
  input  logic        Flush,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic        Valid_D,
  output logic [15:0] Imm16_D,
  output logic [1:0]  EXTOp_D,
  output logic [4:0]  rs_D,
  output logic [4:0]  rt_D,
  output logic [15:0] StallCnt
);

  localparam logic [1:0]  EXT_ZERO  = 2'b00;
  localparam logic [1:0]  EXT_SIGN  = 2'b01;
  localparam logic [1:0]  EXT_LUI   = 2'b10;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic        valid_r;
  logic [15:0] stall_cnt_r;
  logic [1:0]  extop_s;

  // Unlisted opcodes (including the all-zero bubble) fall back to zero-extend.
  function automatic logic [1:0] decode_extop(input logic [5:0] op);
    logic [1:0] mode;
    case (op)
      6'b001101: mode = EXT_ZERO;
      6'b001100: mode = EXT_ZERO;
      6'b001111: mode = EXT_LUI;
      6'b001000: mode = EXT_SIGN;
      6'b100011: mode = EXT_SIGN;
      6'b101011: mode = EXT_SIGN;
      6'b000100: mode = EXT_SIGN;
      default:   mode = EXT_ZERO;
    endcase
    return mode;
  endfunction

  // Pipeline register: flush outranks stall; flush keeps the PC for the bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r <= 32'h0000_0000;
      pc_r    <= PC_RESET;
      valid_r <= 1'b0;
    end else if (Flush) begin
      instr_r <= 32'h0000_0000;
      pc_r    <= PC_F;
      valid_r <= 1'b0;
    end else if (!Stall) begin
      instr_r <= Instr_F;
      pc_r    <= PC_F;
      valid_r <= 1'b1;
    end
  end

  // Saturating count of edges where the stage actually held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (Stall && !Flush && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  // Extender mode decode straight off the registered instruction.
  always_comb begin
    extop_s = decode_extop(instr_r[31:26]);
  end

  assign Instr_D  = instr_r;
  assign PC_D     = pc_r;
  assign Valid_D  = valid_r;
  assign StallCnt = stall_cnt_r;
  assign EXTOp_D  = extop_s;
  assign Imm16_D  = instr_r[15:0];
  assign rs_D     = instr_r[25:21];
  assign rt_D     = instr_r[20:16];

endmodule
